// File: rtl/icache_dm_pkg.sv
// Shared types and address-field helpers for the direct-mapped instruction cache.
// The state enum is shared between the controller and any bound checkers.
package icache_dm_pkg;

  typedef enum logic {
    COMPARE = 1'b0,
    FILL    = 1'b1
  } state_e;

  localparam logic [31:0] NOP = 32'h0;

  function automatic int calc_idx_w(input int num_lines);
    return $clog2(num_lines);
  endfunction

  // Word-aligned lines: two byte-offset bits sit below the index.
  function automatic int calc_tag_w(input int addr_w, input int num_lines);
    return addr_w - $clog2(num_lines) - 2;
  endfunction

endpackage

// File: rtl/icache_dm_array.sv
// Valid/tag/data storage: combinational read, one write port, synchronous clear-all.
// Only the valid bits are reset; tag and data contents are don't-care until written.
module icache_dm_array
  import icache_dm_pkg::*;
#(
  parameter int DATA_W    = 32,
  parameter int NUM_LINES = 16,
  parameter int IDX_W     = 4,
  parameter int TAG_W     = 10
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [IDX_W-1:0]  rd_idx,
  output logic              rd_valid,
  output logic [TAG_W-1:0]  rd_tag,
  output logic [DATA_W-1:0] rd_data,
  input  logic              wr_en,
  input  logic [IDX_W-1:0]  wr_idx,
  input  logic [TAG_W-1:0]  wr_tag,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              clr_all
);

  logic [NUM_LINES-1:0] valid_q;
  logic [NUM_LINES-1:0] valid_d;
  logic [TAG_W-1:0]     tag_mem  [NUM_LINES];
  logic [DATA_W-1:0]    data_mem [NUM_LINES];

  // Clear-all wins over a same-cycle fill so a flush never leaves a line valid.
  always_comb begin
    valid_d = valid_q;
    if (wr_en) valid_d[wr_idx] = 1'b1;
    if (clr_all) valid_d = '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) valid_q <= '0;
    else        valid_q <= valid_d;
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      tag_mem[wr_idx]  <= wr_tag;
      data_mem[wr_idx] <= wr_data;
    end
  end

  assign rd_valid = valid_q[rd_idx];
  assign rd_tag   = tag_mem[rd_idx];
  assign rd_data  = data_mem[rd_idx];

endmodule

// File: rtl/icache_dm_ctrl.sv
// Direct-mapped, single-word-line instruction cache controller between fetch and IM.
// Handshake: the fetch stage holds cpu_req/cpu_addr while IC_stall_out=1; IM returns Instruction one cycle after IM_en_Read.
module icache_dm_ctrl
  import icache_dm_pkg::*;
#(
  parameter int ADDR_W    = 16,
  parameter int DATA_W    = 32,
  parameter int NUM_LINES = 16,
  parameter int CNT_W     = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_req,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic              flush,
  output logic [DATA_W-1:0] cpu_instr,
  output logic              IC_stall_out,
  output logic [ADDR_W-1:0] IM_Address,
  output logic              IM_en_Read,
  input  logic [DATA_W-1:0] Instruction,
  output logic [CNT_W-1:0]  hit_cnt,
  output logic [CNT_W-1:0]  miss_cnt,
  output state_e            dbg_state
);

  localparam int IDX_W = calc_idx_w(NUM_LINES);
  localparam int TAG_W = calc_tag_w(ADDR_W, NUM_LINES);

  state_e             state_q, state_d;
  logic [ADDR_W-1:0]  miss_addr_q, miss_addr_d;
  logic [CNT_W-1:0]   hit_cnt_q, hit_cnt_d;
  logic [CNT_W-1:0]   miss_cnt_q, miss_cnt_d;

  logic [IDX_W-1:0]   cpu_idx;
  logic [TAG_W-1:0]   cpu_tag;
  logic               rd_valid;
  logic [TAG_W-1:0]   rd_tag;
  logic [DATA_W-1:0]  rd_data;
  logic               lookup_hit;
  logic               wr_en;
  logic               clr_all;

  assign cpu_idx    = cpu_addr[IDX_W+1:2];
  assign cpu_tag    = cpu_addr[ADDR_W-1:IDX_W+2];
  assign lookup_hit = cpu_req & rd_valid & (rd_tag == cpu_tag);

  icache_dm_array #(
    .DATA_W    (DATA_W),
    .NUM_LINES (NUM_LINES),
    .IDX_W     (IDX_W),
    .TAG_W     (TAG_W)
  ) u_array (
    .clk      (clk),
    .rst_n    (rst),
    .rd_idx   (cpu_idx),
    .rd_valid (rd_valid),
    .rd_tag   (rd_tag),
    .rd_data  (rd_data),
    .wr_en    (wr_en),
    .wr_idx   (miss_addr_q[IDX_W+1:2]),
    .wr_tag   (miss_addr_q[ADDR_W-1:IDX_W+2]),
    .wr_data  (Instruction),
    .clr_all  (clr_all)
  );

  always_comb begin
    state_d      = state_q;
    miss_addr_d  = miss_addr_q;
    hit_cnt_d    = hit_cnt_q;
    miss_cnt_d   = miss_cnt_q;
    cpu_instr    = DATA_W'(NOP);
    IC_stall_out = 1'b0;
    IM_en_Read   = 1'b0;
    IM_Address   = miss_addr_q;
    wr_en        = 1'b0;
    clr_all      = 1'b0;
    case (state_q)
      COMPARE: begin
        if (flush) begin
          clr_all      = 1'b1;
          IC_stall_out = 1'b1;
        end else if (lookup_hit) begin
          cpu_instr = rd_data;
          if (hit_cnt_q != '1) hit_cnt_d = hit_cnt_q + CNT_W'(1);
        end else if (cpu_req) begin
          IC_stall_out = 1'b1;
          IM_en_Read   = 1'b1;
          IM_Address   = {cpu_addr[ADDR_W-1:2], 2'b00};
          miss_addr_d  = {cpu_addr[ADDR_W-1:2], 2'b00};
          if (miss_cnt_q != '1) miss_cnt_d = miss_cnt_q + CNT_W'(1);
          state_d      = FILL;
        end
      end
      FILL: begin
        // Fill from the latched address so a wandering cpu_addr cannot corrupt a line.
        IC_stall_out = 1'b1;
        wr_en        = 1'b1;
        clr_all      = flush;
        state_d      = COMPARE;
      end
      default: state_d = COMPARE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= COMPARE;
      miss_addr_q <= '0;
      hit_cnt_q   <= '0;
      miss_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      miss_addr_q <= miss_addr_d;
      hit_cnt_q   <= hit_cnt_d;
      miss_cnt_q  <= miss_cnt_d;
    end
  end

  assign hit_cnt   = hit_cnt_q;
  assign miss_cnt  = miss_cnt_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_icache_dm_ctrl.sv
// Bench for icache_dm_ctrl: an IM memory model plus a line-occupancy reference model
// predicting hit/miss, stall cycles, returned data and counter values.
module tb_icache_dm_ctrl;
  import icache_dm_pkg::*;

  localparam int ADDR_W    = 16;
  localparam int DATA_W    = 32;
  localparam int NUM_LINES = 16;
  localparam int CNT_W     = 32;
  localparam int IM_WORDS  = 1 << (ADDR_W - 2);

  logic              clk;
  logic              rst;
  logic              cpu_req;
  logic [ADDR_W-1:0] cpu_addr;
  logic              flush;
  logic [DATA_W-1:0] cpu_instr;
  logic              IC_stall_out;
  logic [ADDR_W-1:0] IM_Address;
  logic              IM_en_Read;
  logic [DATA_W-1:0] Instruction;
  logic [CNT_W-1:0]  hit_cnt;
  logic [CNT_W-1:0]  miss_cnt;
  state_e            dbg_state;

  int tests_run;
  int tests_failed;

  logic [DATA_W-1:0] im_mem [IM_WORDS];

  // Reference model: which word each line currently holds, plus event counts.
  bit ref_valid [NUM_LINES];
  int ref_word  [NUM_LINES];
  int exp_hits;
  int exp_misses;
  logic [DATA_W-1:0] exp_q [$];

  icache_dm_ctrl #(
    .ADDR_W    (ADDR_W),
    .DATA_W    (DATA_W),
    .NUM_LINES (NUM_LINES),
    .CNT_W     (CNT_W)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .cpu_req      (cpu_req),
    .cpu_addr     (cpu_addr),
    .flush        (flush),
    .cpu_instr    (cpu_instr),
    .IC_stall_out (IC_stall_out),
    .IM_Address   (IM_Address),
    .IM_en_Read   (IM_en_Read),
    .Instruction  (Instruction),
    .hit_cnt      (hit_cnt),
    .miss_cnt     (miss_cnt),
    .dbg_state    (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // IM returns the addressed word one cycle after the read-enable cycle.
  initial Instruction = '0;
  always @(posedge clk) begin
    if (IM_en_Read) Instruction <= im_mem[IM_Address[ADDR_W-1:2]];
  end

  // ---------------- reference model ----------------
  function automatic void model_reset();
    for (int i = 0; i < NUM_LINES; i++) begin
      ref_valid[i] = 1'b0;
      ref_word[i]  = -1;
    end
    exp_hits   = 0;
    exp_misses = 0;
  endfunction

  function automatic void model_flush();
    for (int i = 0; i < NUM_LINES; i++) ref_valid[i] = 1'b0;
  endfunction

  // Returns 1 if the fetch hits immediately; a miss is followed by a refetch that hits.
  function automatic bit model_access(input logic [ADDR_W-1:0] a);
    int word;
    int line;
    word = int'(a) / 4;
    line = word % NUM_LINES;
    if (ref_valid[line] && ref_word[line] == word) begin
      exp_hits++;
      return 1'b1;
    end
    ref_valid[line] = 1'b1;
    ref_word[line]  = word;
    exp_misses++;
    exp_hits++;
    return 1'b0;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic apply_reset();
    cpu_req  = 1'b0;
    cpu_addr = '0;
    flush    = 1'b0;
    rst      = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    model_reset();
  endtask

  // Starts just after a rising edge; returns just after the edge that accepts the fetch.
  task automatic fetch(input logic [ADDR_W-1:0] a, output logic [DATA_W-1:0] instr,
                       output int stalls, output logic first_en,
                       output logic [ADDR_W-1:0] first_addr, output bit timed_out);
    cpu_req    = 1'b1;
    cpu_addr   = a;
    stalls     = 0;
    timed_out  = 1'b1;
    first_en   = 1'b0;
    first_addr = '0;
    instr      = '0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (c == 0) begin
        first_en   = IM_en_Read;
        first_addr = IM_Address;
      end
      if (!IC_stall_out) begin
        instr     = cpu_instr;
        timed_out = 1'b0;
        @(posedge clk);
        #1;
        break;
      end
      stalls++;
      @(posedge clk);
      #1;
    end
    cpu_req = 1'b0;
  endtask

  task automatic flush_cycle();
    cpu_req = 1'b0;
    flush   = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    model_flush();
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    apply_reset();
    @(negedge clk);
    tests_run++;
    if (IC_stall_out !== 1'b0 || IM_en_Read !== 1'b0 || cpu_instr !== '0) begin
      tests_failed++;
      $display("FAIL reset_outputs: stall=%b en=%b instr=%h, want 0 0 0",
               IC_stall_out, IM_en_Read, cpu_instr);
    end
    tests_run++;
    if (IM_Address !== '0 || hit_cnt !== '0 || miss_cnt !== '0 || dbg_state !== COMPARE) begin
      tests_failed++;
      $display("FAIL reset_regs: addr=%h hit=%0d miss=%0d state=%0d, want 0 0 0 COMPARE",
               IM_Address, hit_cnt, miss_cnt, dbg_state);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_first_miss();
    logic [DATA_W-1:0] instr;
    logic [ADDR_W-1:0] fa;
    logic fe;
    int st;
    bit to;
    apply_reset();
    fetch(16'h0014, instr, st, fe, fa, to);
    tests_run++;
    if (to || st != 2 || instr !== 32'h20080005) begin
      tests_failed++;
      $display("FAIL first_miss: timeout=%0d stalls=%0d instr=%h, want 0 2 20080005", to, st, instr);
    end
    tests_run++;
    if (fe !== 1'b1 || fa !== 16'h0014) begin
      tests_failed++;
      $display("FAIL first_miss_im: en=%b addr=%h, want 1 0014", fe, fa);
    end
    tests_run++;
    if (hit_cnt !== 32'd1 || miss_cnt !== 32'd1) begin
      tests_failed++;
      $display("FAIL first_miss_cnt: hit=%0d miss=%0d, want 1 1", hit_cnt, miss_cnt);
    end
  endtask

  task automatic test_sequential();
    logic [DATA_W-1:0] instr;
    logic [ADDR_W-1:0] fa;
    logic fe;
    int st;
    bit to;
    bit exp_hit;
    apply_reset();
    for (int pass = 0; pass < 3; pass++) begin
      for (int w = 0; w < 16; w++) begin
        exp_hit = model_access(ADDR_W'(w * 4));
        fetch(ADDR_W'(w * 4), instr, st, fe, fa, to);
        tests_run++;
        if (to || st != (exp_hit ? 0 : 2) || instr !== im_mem[w]) begin
          tests_failed++;
          $display("FAIL seq_fetch p%0d w%0d: timeout=%0d stalls=%0d instr=%h, want 0 %0d %h",
                   pass, w, to, st, instr, exp_hit ? 0 : 2, im_mem[w]);
        end
      end
    end
    tests_run++;
    if (hit_cnt !== 32'd48 || miss_cnt !== 32'd16) begin
      tests_failed++;
      $display("FAIL seq_counts: hit=%0d miss=%0d, want 48 16", hit_cnt, miss_cnt);
    end
  endtask

  task automatic test_conflict();
    logic [DATA_W-1:0] instr;
    logic [ADDR_W-1:0] fa;
    logic [ADDR_W-1:0] addrs [3];
    logic fe;
    int st;
    bit to;
    addrs[0] = 16'h0004;
    addrs[1] = 16'h0044;
    addrs[2] = 16'h0004;
    apply_reset();
    for (int i = 0; i < 3; i++) begin
      fetch(addrs[i], instr, st, fe, fa, to);
      tests_run++;
      if (to || st != 2 || instr !== im_mem[addrs[i][ADDR_W-1:2]]) begin
        tests_failed++;
        $display("FAIL conflict %0d: timeout=%0d stalls=%0d instr=%h, want 0 2 %h",
                 i, to, st, instr, im_mem[addrs[i][ADDR_W-1:2]]);
      end
    end
    tests_run++;
    if (miss_cnt !== 32'd3) begin
      tests_failed++;
      $display("FAIL conflict_cnt: miss=%0d, want 3", miss_cnt);
    end
  endtask

  task automatic test_flush();
    logic [DATA_W-1:0] instr;
    logic [ADDR_W-1:0] fa;
    logic fe;
    int st;
    bit to;
    logic [CNT_W-1:0] miss_before;
    logic [CNT_W-1:0] hit_before;
    apply_reset();
    for (int w = 0; w < 4; w++) fetch(ADDR_W'(w * 4), instr, st, fe, fa, to);
    miss_before = miss_cnt;
    hit_before  = hit_cnt;
    cpu_req = 1'b0;
    flush   = 1'b1;
    @(negedge clk);
    tests_run++;
    if (IC_stall_out !== 1'b1 || IM_en_Read !== 1'b0 || cpu_instr !== '0) begin
      tests_failed++;
      $display("FAIL flush_cycle: stall=%b en=%b instr=%h, want 1 0 0",
               IC_stall_out, IM_en_Read, cpu_instr);
    end
    @(posedge clk);
    #1;
    flush = 1'b0;
    tests_run++;
    if (hit_cnt !== hit_before || miss_cnt !== miss_before) begin
      tests_failed++;
      $display("FAIL flush_no_count: hit=%0d miss=%0d, want %0d %0d",
               hit_cnt, miss_cnt, hit_before, miss_before);
    end
    for (int w = 0; w < 4; w++) begin
      fetch(ADDR_W'(w * 4), instr, st, fe, fa, to);
      tests_run++;
      if (to || st != 2 || instr !== im_mem[w]) begin
        tests_failed++;
        $display("FAIL flush_refetch w%0d: timeout=%0d stalls=%0d instr=%h, want 0 2 %h",
                 w, to, st, instr, im_mem[w]);
      end
    end
    tests_run++;
    if (miss_cnt !== miss_before + 32'd4) begin
      tests_failed++;
      $display("FAIL flush_miss_cnt: miss=%0d, want %0d", miss_cnt, miss_before + 32'd4);
    end
  endtask

  task automatic test_flush_in_fill();
    logic [DATA_W-1:0] instr;
    logic [ADDR_W-1:0] fa;
    logic fe;
    int st;
    bit to;
    apply_reset();
    cpu_req  = 1'b1;
    cpu_addr = 16'h0008;
    @(posedge clk);
    #1;
    flush = 1'b1;
    @(negedge clk);
    tests_run++;
    if (dbg_state !== FILL || IC_stall_out !== 1'b1 || IM_Address !== 16'h0008) begin
      tests_failed++;
      $display("FAIL fill_flush_state: state=%0d stall=%b addr=%h, want FILL 1 0008",
               dbg_state, IC_stall_out, IM_Address);
    end
    @(posedge clk);
    #1;
    flush = 1'b0;
    fetch(16'h0008, instr, st, fe, fa, to);
    tests_run++;
    if (to || st != 2 || instr !== im_mem[2]) begin
      tests_failed++;
      $display("FAIL fill_flush_refetch: timeout=%0d stalls=%0d instr=%h, want 0 2 %h",
               to, st, instr, im_mem[2]);
    end
    tests_run++;
    if (miss_cnt !== 32'd2 || hit_cnt !== 32'd1) begin
      tests_failed++;
      $display("FAIL fill_flush_cnt: hit=%0d miss=%0d, want 1 2", hit_cnt, miss_cnt);
    end
  endtask

  task automatic test_reset_mid_fill();
    logic [DATA_W-1:0] instr;
    logic [ADDR_W-1:0] fa;
    logic fe;
    int st;
    bit to;
    apply_reset();
    fetch(16'h0000, instr, st, fe, fa, to);
    cpu_req  = 1'b1;
    cpu_addr = 16'h0100;
    @(posedge clk);
    #1;
    cpu_req = 1'b0;
    rst     = 1'b0;
    #1;
    tests_run++;
    if (IC_stall_out !== 1'b0 || IM_en_Read !== 1'b0 || IM_Address !== '0 ||
        cpu_instr !== '0 || dbg_state !== COMPARE) begin
      tests_failed++;
      $display("FAIL async_reset: stall=%b en=%b addr=%h instr=%h state=%0d, want 0 0 0000 0 COMPARE",
               IC_stall_out, IM_en_Read, IM_Address, cpu_instr, dbg_state);
    end
    tests_run++;
    if (hit_cnt !== '0 || miss_cnt !== '0) begin
      tests_failed++;
      $display("FAIL async_reset_cnt: hit=%0d miss=%0d, want 0 0", hit_cnt, miss_cnt);
    end
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    model_reset();
    fetch(16'h0000, instr, st, fe, fa, to);
    tests_run++;
    if (to || st != 2 || instr !== im_mem[0]) begin
      tests_failed++;
      $display("FAIL reset_refetch: timeout=%0d stalls=%0d instr=%h, want 0 2 %h",
               to, st, instr, im_mem[0]);
    end
  endtask

  task automatic test_random();
    logic [DATA_W-1:0] instr;
    logic [DATA_W-1:0] exp_instr;
    logic [ADDR_W-1:0] fa;
    logic [ADDR_W-1:0] a;
    logic fe;
    int st;
    bit to;
    bit exp_hit;
    apply_reset();
    for (int n = 0; n < 300; n++) begin
      if ($urandom_range(0, 19) == 0) flush_cycle();
      a = ADDR_W'($urandom_range(0, 63) * 4 + $urandom_range(0, 3));
      exp_hit = model_access(a);
      exp_q.push_back(im_mem[a[ADDR_W-1:2]]);
      fetch(a, instr, st, fe, fa, to);
      exp_instr = exp_q.pop_front();
      tests_run++;
      if (to || st != (exp_hit ? 0 : 2) || instr !== exp_instr) begin
        tests_failed++;
        $display("FAIL random %0d addr=%h: timeout=%0d stalls=%0d instr=%h, want 0 %0d %h",
                 n, a, to, st, instr, exp_hit ? 0 : 2, exp_instr);
      end
      if (!exp_hit) begin
        tests_run++;
        if (fe !== 1'b1 || fa !== {a[ADDR_W-1:2], 2'b00}) begin
          tests_failed++;
          $display("FAIL random_im %0d: en=%b addr=%h, want 1 %h",
                   n, fe, fa, {a[ADDR_W-1:2], 2'b00});
        end
      end
    end
    tests_run++;
    if (hit_cnt !== CNT_W'(exp_hits) || miss_cnt !== CNT_W'(exp_misses)) begin
      tests_failed++;
      $display("FAIL random_cnt: hit=%0d miss=%0d, want %0d %0d",
               hit_cnt, miss_cnt, exp_hits, exp_misses);
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    tests_run    = 0;
    tests_failed = 0;
    rst      = 1'b0;
    cpu_req  = 1'b0;
    cpu_addr = '0;
    flush    = 1'b0;
    for (int i = 0; i < IM_WORDS; i++) im_mem[i] = $urandom;
    im_mem[5] = 32'h20080005;
    model_reset();

    test_reset();
    test_first_miss();
    test_sequential();
    test_conflict();
    test_flush();
    test_flush_in_fill();
    test_reset_mid_fill();
    test_random();

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, want completion");
    $fatal(1, "watchdog");
  end

endmodule
